// File: rtl/dpram_fifo_ctrl.sv
// dpram_fifo_ctrl: FIFO controller over an external dual-port RAM with a 2-entry show-ahead output buffer
module dpram_fifo_ctrl #(
  parameter int AWIDTH    = 10,
  parameter int NUM_WORDS = 1024,
  parameter int DWIDTH    = 32
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DWIDTH-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DWIDTH-1:0] out_data,
  output logic [AWIDTH+1:0] count,
  output logic [AWIDTH-1:0] ram_address_a,
  output logic              ram_wren_a,
  output logic [DWIDTH-1:0] ram_data_a,
  output logic [AWIDTH-1:0] ram_address_b,
  output logic              ram_wren_b,
  input  logic [DWIDTH-1:0] ram_out_b
);
  localparam logic [AWIDTH:0]   FULL = (AWIDTH+1)'(NUM_WORDS);
  localparam logic [AWIDTH-1:0] LAST = AWIDTH'(NUM_WORDS - 1);
  logic              rst_sync_q;
  logic [AWIDTH-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AWIDTH:0]   ram_count_q, ram_count_d;
  logic              inflight_q, inflight_d;
  logic [1:0]        buf_count_q, buf_count_d, keep;
  logic [DWIDTH-1:0] buf0_q, buf0_d, buf1_q, buf1_d;
  logic              push, pop, rd_issue;
  logic [2:0]        occ;
  assign in_ready      = rst_sync_q & ~flush & (ram_count_q < FULL);
  assign push          = in_valid & in_ready;
  assign out_valid     = buf_count_q != 2'd0;
  assign pop           = out_valid & out_ready;
  assign out_data      = buf0_q;
  // Words that will sit outside the RAM after this edge, excluding a new issue
  assign occ           = 3'(buf_count_q) + 3'(inflight_q) - 3'(pop);
  assign rd_issue      = (ram_count_q != '0) & ~flush & (occ < 3'd2);
  assign ram_address_a = wr_ptr_q;
  assign ram_wren_a    = push;
  assign ram_data_a    = in_data;
  assign ram_address_b = rd_ptr_q;
  assign ram_wren_b    = 1'b0;
  assign count         = (AWIDTH+2)'(ram_count_q) + (AWIDTH+2)'(inflight_q) + (AWIDTH+2)'(buf_count_q);
  // Next state: pointers wrap, a pop shifts the buffer and a RAM result appends behind what remains
  always_comb begin
    wr_ptr_d    = push ? (wr_ptr_q == LAST ? '0 : wr_ptr_q + AWIDTH'(1)) : wr_ptr_q;
    rd_ptr_d    = rd_issue ? (rd_ptr_q == LAST ? '0 : rd_ptr_q + AWIDTH'(1)) : rd_ptr_q;
    ram_count_d = ram_count_q + (AWIDTH+1)'(push) - (AWIDTH+1)'(rd_issue);
    inflight_d  = rd_issue;
    keep        = buf_count_q - 2'(pop);
    buf0_d      = (inflight_q && keep == 2'd0) ? ram_out_b : (pop ? buf1_q : buf0_q);
    buf1_d      = (inflight_q && keep == 2'd1) ? ram_out_b : buf1_q;
    buf_count_d = keep + 2'(inflight_q);
  end
  // Hold off pushes until the first edge after reset release
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) rst_sync_q <= 1'b0;
    else         rst_sync_q <= 1'b1;
  end
  // FIFO state; flush clears everything and drops any read still in flight
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      ram_count_q <= '0;
      inflight_q  <= 1'b0;
      buf_count_q <= '0;
      buf0_q      <= '0;
      buf1_q      <= '0;
    end else if (flush) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      ram_count_q <= '0;
      inflight_q  <= 1'b0;
      buf_count_q <= '0;
      buf0_q      <= '0;
      buf1_q      <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      ram_count_q <= ram_count_d;
      inflight_q  <= inflight_d;
      buf_count_q <= buf_count_d;
      buf0_q      <= buf0_d;
      buf1_q      <= buf1_d;
    end
  end
endmodule

// File: tb/tb_dpram_fifo_ctrl.sv
// tb_dpram_fifo_ctrl: scenario tasks checked against a queue model of FIFO order and occupancy
module tb_dpram_fifo_ctrl;
  localparam int AW = 10;
  localparam int NW = 1024;
  localparam int DW = 32;
  logic clk, resetn, flush, in_valid, in_ready, out_valid, out_ready;
  logic [DW-1:0] in_data, out_data, ram_data_a, ram_out_b;
  logic [AW+1:0] count;
  logic [AW-1:0] ram_address_a, ram_address_b;
  logic ram_wren_a, ram_wren_b;
  logic [DW-1:0] mem [0:NW-1];
  logic [DW-1:0] q[$];
  int n_cmp, n_err, wr_total, obs_wr_idx;
  logic obs_push, obs_pop, obs_wren, obs_ready, obs_had;
  logic [AW-1:0] obs_addr_a;
  logic [DW-1:0] obs_data, obs_head;

  dpram_fifo_ctrl #(.AWIDTH(AW), .NUM_WORDS(NW), .DWIDTH(DW)) dut (
    .clk(clk), .resetn(resetn), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .count(count),
    .ram_address_a(ram_address_a), .ram_wren_a(ram_wren_a), .ram_data_a(ram_data_a),
    .ram_address_b(ram_address_b), .ram_wren_b(ram_wren_b), .ram_out_b(ram_out_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial for (int i = 0; i < NW; i++) mem[i] = 32'hDEAD_0000 | i;

  // dual-port RAM: synchronous write on A, registered read on B
  always @(posedge clk) begin
    if (ram_wren_a) mem[ram_address_a] <= ram_data_a;
    ram_out_b <= mem[ram_address_b];
  end

  // One cycle: drive inputs after negedge, sample settled outputs, update the model at posedge
  task automatic tick(input logic iv, input logic [DW-1:0] d, input logic ordy, input logic fl);
    @(negedge clk);
    in_valid = iv; in_data = d; out_ready = ordy; flush = fl;
    #1;
    obs_push = in_valid & in_ready;
    obs_pop = out_valid & out_ready;
    obs_data = out_data;
    obs_wren = ram_wren_a;
    obs_addr_a = ram_address_a;
    obs_ready = in_ready;
    obs_had = q.size() != 0;
    obs_head = obs_had ? q[0] : 32'h0BAD_0BAD;
    obs_wr_idx = wr_total;
    @(posedge clk);
    if (fl) begin
      q.delete();
      wr_total = 0;
    end else begin
      if (obs_pop && obs_had) void'(q.pop_front());
      if (obs_push) begin
        q.push_back(d);
        wr_total++;
      end
    end
    #1;
  endtask

  task automatic test_reset;
    resetn = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_cmp++; if (out_data !== 32'h0) begin n_err++; $display("FAIL reset_out_data: got %h want 0", out_data); end
    n_cmp++; if (count !== 12'd0) begin n_err++; $display("FAIL reset_count: got %0d want 0", count); end
    n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
    n_cmp++; if (ram_wren_b !== 1'b0) begin n_err++; $display("FAIL wren_b: got %b want 0", ram_wren_b); end
    @(negedge clk); resetn = 1'b1;
    @(posedge clk); #1;
    q.delete(); wr_total = 0;
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL post_reset_in_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_single;
    tick(1'b1, 32'hA0, 1'b1, 1'b0);
    n_cmp++; if (obs_wren !== 1'b1 || obs_addr_a !== 10'd0) begin n_err++; $display("FAIL single_write: wren %b addr %0d want 1 0", obs_wren, obs_addr_a); end
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL single_lat1: out_valid %b want 0", out_valid); end
    tick(1'b0, '0, 1'b1, 1'b0);
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL single_lat2: out_valid %b want 0", out_valid); end
    tick(1'b0, '0, 1'b1, 1'b0);
    n_cmp++; if (out_valid !== 1'b1 || out_data !== 32'hA0) begin n_err++; $display("FAIL single_lat3: out_valid %b data %h want 1 a0", out_valid, out_data); end
    tick(1'b0, '0, 1'b1, 1'b0);
    n_cmp++; if (!obs_pop || obs_data !== 32'hA0) begin n_err++; $display("FAIL single_pop: pop %b data %h want 1 a0", obs_pop, obs_data); end
    n_cmp++; if (count !== 12'd0) begin n_err++; $display("FAIL single_count: got %0d want 0", count); end
  endtask

  task automatic test_stream;
    int nxt, popped, cyc;
    nxt = 0; popped = 0; cyc = 0;
    while (popped < 2000 && cyc < 2100) begin
      tick(nxt < 2000, DW'(nxt), 1'b1, 1'b0);
      cyc++;
      if (obs_push) begin
        n_cmp++; if (obs_addr_a !== AW'(obs_wr_idx % NW)) begin n_err++; $display("FAIL stream_addr: got %0d want %0d", obs_addr_a, obs_wr_idx % NW); end
        nxt++;
      end
      if (obs_pop) begin
        n_cmp++; if (!obs_had || obs_data !== obs_head) begin n_err++; $display("FAIL stream_data: got %h want %h", obs_data, obs_head); end
        popped++;
      end
      n_cmp++; if (count !== 12'(q.size())) begin n_err++; $display("FAIL stream_count: got %0d want %0d", count, q.size()); end
    end
    n_cmp++; if (popped !== 2000 || cyc !== 2003) begin n_err++; $display("FAIL stream_throughput: popped %0d in %0d cycles want 2000 in 2003", popped, cyc); end
  endtask

  task automatic test_backpressure;
    int pushed, popped, cyc;
    pushed = 0; popped = 0; cyc = 0;
    while (pushed < 1026 && cyc < 1200) begin
      tick(1'b1, DW'(pushed), 1'b0, 1'b0);
      cyc++;
      if (obs_push) pushed++;
      n_cmp++; if (count !== 12'(q.size())) begin n_err++; $display("FAIL bp_fill_count: got %0d want %0d", count, q.size()); end
    end
    n_cmp++; if (count !== 12'd1026 || in_ready !== 1'b0) begin n_err++; $display("FAIL bp_full: count %0d in_ready %b want 1026 0", count, in_ready); end
    n_cmp++; if (out_valid !== 1'b1 || out_data !== 32'h0) begin n_err++; $display("FAIL bp_head: valid %b data %h want 1 0", out_valid, out_data); end
    tick(1'b1, 32'hBAD, 1'b0, 1'b0);
    n_cmp++; if (obs_push !== 1'b0) begin n_err++; $display("FAIL bp_overflow: push %b want 0", obs_push); end
    cyc = 0;
    while (q.size() > 0 && cyc < 1200) begin
      tick(1'b0, '0, 1'b1, 1'b0);
      cyc++;
      if (obs_pop) begin
        n_cmp++; if (!obs_had || obs_data !== obs_head) begin n_err++; $display("FAIL bp_data: got %h want %h", obs_data, obs_head); end
        popped++;
      end
    end
    n_cmp++; if (popped !== 1026 || count !== 12'd0) begin n_err++; $display("FAIL bp_drain: popped %0d count %0d want 1026 0", popped, count); end
  endtask

  task automatic test_alternate;
    int cyc;
    for (int i = 0; i < 700; i++) begin
      tick(i < 300 ? 1'b1 : 1'(i >= 500 ? 0 : $urandom_range(0, 1)), $urandom, i < 300 ? 1'(i % 2) : 1'($urandom_range(0, 1)), 1'b0);
      if (obs_pop) begin
        n_cmp++; if (!obs_had || obs_data !== obs_head) begin n_err++; $display("FAIL alt_data: got %h want %h", obs_data, obs_head); end
      end
      n_cmp++; if (count !== 12'(q.size())) begin n_err++; $display("FAIL alt_count: got %0d want %0d", count, q.size()); end
    end
    cyc = 0;
    while (q.size() > 0 && cyc < 600) begin
      tick(1'b0, '0, 1'b1, 1'b0);
      cyc++;
      if (obs_pop) begin
        n_cmp++; if (!obs_had || obs_data !== obs_head) begin n_err++; $display("FAIL alt_drain_data: got %h want %h", obs_data, obs_head); end
      end
    end
    n_cmp++; if (count !== 12'd0 || out_valid !== 1'b0) begin n_err++; $display("FAIL alt_empty: count %0d valid %b want 0 0", count, out_valid); end
  endtask

  task automatic test_flush;
    int cyc;
    logic seen;
    for (int i = 0; i < 6; i++) tick(1'b1, DW'(100 + i), 1'b0, 1'b0);
    repeat (3) tick(1'b0, '0, 1'b0, 1'b0);
    tick(1'b0, '0, 1'b1, 1'b0);
    n_cmp++; if (count !== 12'd5) begin n_err++; $display("FAIL flush_pre_count: got %0d want 5", count); end
    tick(1'b1, 32'hDEAD, 1'b0, 1'b1);
    n_cmp++; if (obs_push !== 1'b0 || obs_ready !== 1'b0) begin n_err++; $display("FAIL flush_no_push: push %b ready %b want 0 0", obs_push, obs_ready); end
    n_cmp++; if (out_valid !== 1'b0 || count !== 12'd0) begin n_err++; $display("FAIL flush_clear: valid %b count %0d want 0 0", out_valid, count); end
    tick(1'b1, 32'h55, 1'b1, 1'b0);
    n_cmp++; if (obs_addr_a !== 10'd0) begin n_err++; $display("FAIL flush_wr_ptr: got %0d want 0", obs_addr_a); end
    seen = 1'b0; cyc = 0;
    while (!seen && cyc < 10) begin
      tick(1'b0, '0, 1'b1, 1'b0);
      cyc++;
      seen = obs_pop;
    end
    n_cmp++; if (!seen || obs_data !== 32'h55) begin n_err++; $display("FAIL flush_first_word: seen %b data %h want 1 55", seen, obs_data); end
    tick(1'b0, '0, 1'b1, 1'b0);
    n_cmp++; if (obs_pop !== 1'b0 || count !== 12'd0) begin n_err++; $display("FAIL flush_stale: pop %b count %0d want 0 0", obs_pop, count); end
  endtask

  task automatic test_async_reset;
    for (int i = 0; i < 6; i++) tick(1'b1, DW'(i + 7), 1'b1, 1'b0);
    @(negedge clk);
    in_valid = 1'b1; out_ready = 1'b1;
    #2 resetn = 1'b0;
    #1;
    n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b0) begin n_err++; $display("FAIL areset_outputs: valid %b ready %b want 0 0", out_valid, in_ready); end
    n_cmp++; if (ram_wren_a !== 1'b0 || count !== 12'd0) begin n_err++; $display("FAIL areset_state: wren %b count %0d want 0 0", ram_wren_a, count); end
    @(posedge clk); #1;
    n_cmp++; if (ram_wren_a !== 1'b0) begin n_err++; $display("FAIL areset_hold_wren: got %b want 0", ram_wren_a); end
    q.delete(); wr_total = 0;
    @(negedge clk); in_valid = 1'b0; resetn = 1'b1;
    @(posedge clk); #1;
    test_single();
  endtask

  initial begin
    n_cmp = 0; n_err = 0; wr_total = 0;
    test_reset();
    test_single();
    test_stream();
    test_backpressure();
    test_alternate();
    test_flush();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
